// File: rtl/data_ram_pkg.sv
// Shared definitions for the data-RAM responder: widths, defaults, FSM encoding
// and the byte-merge helper used by the store.
package data_ram_pkg;

    localparam int DATA_W      = 32;
    localparam int BYTES       = 4;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_LATENCY = 2;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // New bytes where the enable is set, old bytes elsewhere.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BYTES-1:0]  wen
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BYTES; i++) begin
            if (wen[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_ram_store.sv
// Word-addressed data store: one masked synchronous write that also registers
// the merged word as read data, plus an asynchronous debug read port.
module data_ram_store
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              commit_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BYTES-1:0]  wen_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [ADDR_W-1:0] test_addr_i,
    output logic [DATA_W-1:0] test_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] merged;

    // A read is a commit with no enables: the word is rewritten unchanged.
    assign merged = merge_bytes(mem_q[addr_i], wdata_i, wen_i);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else if (commit_i) begin
            mem_q[addr_i] <= merged;
            rdata_q       <= merged;
        end
    end

    assign rdata_o     = rdata_q;
    assign test_data_o = mem_q[test_addr_i];

endmodule

// File: rtl/data_ram_responder.sv
// Single-outstanding request/response front end for the data store, with a
// fixed access latency counted from the accept edge.
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BYTES-1:0]  req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic [ADDR_W-1:0] test_addr,
    output logic [DATA_W-1:0] test_data,
    output state_t            dbg_state
);

    // Handshake: a transfer happens on an edge where valid and ready are both
    // high; ready/valid driven here depend on state only, never on the peer.

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTES-1:0]  wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              commit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wen_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wen_q   <= req_wen;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    data_ram_store #(
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk         (clk),
        .resetn      (resetn),
        .commit_i    (commit),
        .addr_i      (addr_q),
        .wen_i       (wen_q),
        .wdata_i     (wdata_q),
        .rdata_o     (resp_rdata),
        .test_addr_i (test_addr),
        .test_data_o (test_data)
    );

    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: scoreboarded LATENCY=2 instance plus
// LATENCY=1 and LATENCY=15 instances for the latency/wrap sweep.
module tb_data_ram_responder;
    import data_ram_pkg::*;

    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (LATENCY=2) ----------------
    logic          req_valid, req_ready, resp_valid, resp_ready;
    logic [3:0]    req_wen;
    logic [AW-1:0] req_addr, test_addr;
    logic [31:0]   req_wdata, resp_rdata, test_data;
    state_t        dbg_state;

    data_ram_responder #(.ADDR_W(AW), .LATENCY(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .test_addr(test_addr), .test_data(test_data), .dbg_state(dbg_state)
    );

    // ---------------- sweep DUTs (LATENCY=1, 15) ----------------
    logic          s_req_valid, s_resp_ready;
    logic [3:0]    s_req_wen;
    logic [AW-1:0] s_req_addr, s_test_addr;
    logic [31:0]   s_req_wdata;
    logic          s1_req_ready, s1_resp_valid, s15_req_ready, s15_resp_valid;
    logic [31:0]   s1_rdata, s1_test_data, s15_rdata, s15_test_data;
    state_t        s1_state, s15_state;

    data_ram_responder #(.ADDR_W(AW), .LATENCY(1)) dut_l1 (
        .clk(clk), .resetn(resetn),
        .req_valid(s_req_valid), .req_ready(s1_req_ready), .req_wen(s_req_wen),
        .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .resp_valid(s1_resp_valid), .resp_ready(s_resp_ready), .resp_rdata(s1_rdata),
        .test_addr(s_test_addr), .test_data(s1_test_data), .dbg_state(s1_state)
    );

    data_ram_responder #(.ADDR_W(AW), .LATENCY(15)) dut_l15 (
        .clk(clk), .resetn(resetn),
        .req_valid(s_req_valid), .req_ready(s15_req_ready), .req_wen(s_req_wen),
        .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .resp_valid(s15_resp_valid), .resp_ready(s_resp_ready), .resp_rdata(s15_rdata),
        .test_addr(s_test_addr), .test_data(s15_test_data), .dbg_state(s15_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int accept_cyc = 0;
    logic prev_valid = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: latency on each rising resp_valid, data on each completed response.
    always @(negedge clk) begin
        if (resetn) begin
            if (resp_valid && !prev_valid) chk("latency", 32'(cyc - accept_cyc), 32'd2);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got %h expected none", resp_rdata);
                end else begin
                    chk("resp_rdata", resp_rdata, exp_q.pop_front());
                end
            end
        end
        prev_valid = resp_valid;
    end

    // ---------------- driver tasks (called #1 after a posedge) ----------------
    task automatic issue(input logic [3:0] wen, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp);
        int b = 0;
        while (!req_ready && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 100) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        accept_cyc = cyc;
        req_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int b = 0;
        while (!(exp_q.size() == 0 && req_ready) && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 100) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic sweep_req(input logic [3:0] wen, input logic [AW-1:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp);
        int lat1 = 0;
        int lat15 = 0;
        s_req_valid = 1'b1;
        s_req_wen   = wen;
        s_req_addr  = addr;
        s_req_wdata = wdata;
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (s1_resp_valid && lat1 == 0) begin
                lat1 = i;
                chk("l1_rdata", s1_rdata, exp);
            end
            if (s15_resp_valid && lat15 == 0) begin
                lat15 = i;
                chk("l15_rdata", s15_rdata, exp);
            end
        end
        chk("l1_latency", 32'(lat1), 32'd1);
        chk("l15_latency", 32'(lat15), 32'd15);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] held;
        int b;
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
        resp_ready = 1; test_addr = 0;
        s_req_valid = 0; s_req_wen = 0; s_req_addr = 0; s_req_wdata = 0;
        s_resp_ready = 1; s_test_addr = 0;

        // Reset values
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        for (int i = 0; i < 32; i++) begin
            test_addr = AW'(i);
            #1;
            chk("rst_test_data", test_data, 32'd0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Full write, with the debug port observed around the write edge
        issue(4'hF, 5'd3, 32'h12345678, 32'h12345678);
        test_addr = 5'd3;
        #1 chk("dbg_before_e0", test_data, 32'd0);
        @(posedge clk); #1;
        chk("dbg_before_e2", test_data, 32'd0);
        @(posedge clk); #1;
        chk("dbg_after_e2", test_data, 32'h12345678);
        wait_idle();

        // Byte merge, read-back, merge into a zero word
        issue(4'b0101, 5'd3, 32'hAABBCCDD, 32'h12BB56DD);
        wait_idle();
        issue(4'b0000, 5'd3, 32'hFFFFFFFF, 32'h12BB56DD);
        wait_idle();
        chk("read_no_change", test_data, 32'h12BB56DD);
        issue(4'b1010, 5'd5, 32'h11223344, 32'h11003300);
        wait_idle();

        // Backpressure: response held, requests ignored
        resp_ready = 1'b0;
        issue(4'hF, 5'd10, 32'h0F0F0F0F, 32'h0F0F0F0F);
        b = 0;
        while (!resp_valid && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        held = resp_rdata;
        chk("bp_rdata_first", held, 32'h0F0F0F0F);
        req_valid = 1'b1; req_wen = 4'hF; req_addr = 5'd11; req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_rdata_stable", resp_rdata, held);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_state", {30'd0, dbg_state}, {30'd0, ST_RESP});
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        test_addr = 5'd11;
        #1 chk("bp_ignored_req", test_data, 32'd0);
        wait_idle();

        // Reset in the middle of a write
        issue(4'hF, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF);
        chk("mid_state_wait", {30'd0, dbg_state}, {30'd0, ST_WAIT});
        void'(exp_q.pop_back());
        resetn = 1'b0;
        #1;
        chk("mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_resp_rdata", resp_rdata, 32'd0);
        test_addr = 5'd7;
        #1 chk("mid_mem7", test_data, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_mem7", test_data, 32'd0);
        test_addr = 5'd3;
        #1 chk("post_rst_mem3", test_data, 32'd0);
        issue(4'b0000, 5'd7, 32'h0, 32'h0);
        wait_idle();

        // Latency sweep and address wrap ends on the LATENCY=1/15 instances
        sweep_req(4'hF, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D);
        s_test_addr = 5'd31;
        #1;
        chk("l1_mem31", s1_test_data, 32'hCAFEF00D);
        chk("l15_mem31", s15_test_data, 32'hCAFEF00D);
        sweep_req(4'hF, 5'd0, 32'h0BADBEEF, 32'h0BADBEEF);
        chk("l1_mem31_kept", s1_test_data, 32'hCAFEF00D);
        chk("l15_mem31_kept", s15_test_data, 32'hCAFEF00D);
        s_test_addr = 5'd0;
        #1;
        chk("l1_mem0", s1_test_data, 32'h0BADBEEF);
        chk("l15_mem0", s15_test_data, 32'h0BADBEEF);
        sweep_req(4'b0000, 5'd31, 32'h0, 32'hCAFEF00D);

        if (exp_q.size() != 0) chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
